lc3_dmem_responder: RTL

//  Memory-side responder for the LC3 data-cache refill/write protocol (rrqst/rrdy/rdrdy/rdacpt, wrqst/wacpt).

---
 rtl/lc3_dmem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lc3_dmem_responder.sv
// Memory-side responder for the LC3 data-cache refill/write-through protocol.
// One transaction at a time over a behavioural backing store, plus a protocol-free preload port.
module lc3_dmem_responder #(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rrqst,
  input  logic        wrqst,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        rdacpt,
  output logic        rrdy,
  output logic        rdrdy,
  output logic [63:0] rdata,
  output logic        wacpt,
  output logic        busy,
  input  logic        init_we,
  input  logic [15:0] init_addr,
  input  logic [15:0] init_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_ACK} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [AW-1:0]   addr_reg;
  logic [15:0]     din_reg;
  logic            rrdy_reg;
  logic            rdrdy_reg;
  logic            wacpt_reg;
  logic [63:0]     rdata_reg;

  logic [15:0]     mem [DEPTH];
  logic [15:0]     blk_word [4];
  logic            commit;
  logic [AW-1:0]   wr_idx;
  logic [15:0]     wr_data;
  logic            unused_bits;

  assign unused_bits = ^{addr[15:AW], init_addr[15:AW]};

  // Word k of the aligned block; index arithmetic wraps naturally within AW bits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_blk
      assign blk_word[gi] = mem[{addr_reg[AW-1:2], 2'(gi)}];
    end
  endgenerate

  // With a one-cycle write latency the commit happens straight out of IDLE,
  // before addr/din have been latched, so the live inputs are used there.
  always_comb begin
    commit  = 1'b0;
    wr_idx  = addr_reg;
    wr_data = din_reg;
    if (!reset) begin
      if (state_reg == WR_WAIT && cnt_reg == 4'd0) begin
        commit = 1'b1;
      end else if (state_reg == IDLE && wrqst && WR_LAT == 1) begin
        commit  = 1'b1;
        wr_idx  = addr[AW-1:0];
        wr_data = din;
      end
    end
  end

  // Backing store is never cleared; the protocol write is ordered last so it wins a collision.
  always_ff @(posedge clock) begin
    if (init_we) mem[init_addr[AW-1:0]] <= init_data;
    if (commit)  mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      din_reg   <= 16'd0;
      rrdy_reg  <= 1'b0;
      rdrdy_reg <= 1'b0;
      wacpt_reg <= 1'b0;
      rdata_reg <= 64'd0;
    end else begin
      rrdy_reg  <= 1'b0;
      wacpt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wrqst) begin
            addr_reg <= addr[AW-1:0];
            din_reg  <= din;
            if (WR_LAT > 1) begin
              state_reg <= WR_WAIT;
              cnt_reg   <= 4'(WR_LAT - 2);
            end else begin
              state_reg <= WR_ACK;
              wacpt_reg <= 1'b1;
            end
          end else if (rrqst) begin
            addr_reg  <= {addr[AW-1:2], 2'b00};
            state_reg <= RD_WAIT;
            cnt_reg   <= 4'(RD_LAT - 1);
            rrdy_reg  <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt_reg == 4'd0) begin
            rdata_reg <= {blk_word[3], blk_word[2], blk_word[1], blk_word[0]};
            state_reg <= RD_DATA;
            rdrdy_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RD_DATA: begin
          if (rdacpt) begin
            state_reg <= IDLE;
            rdrdy_reg <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= WR_ACK;
            wacpt_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        WR_ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rrdy  = rrdy_reg;
  assign rdrdy = rdrdy_reg;
  assign wacpt = wacpt_reg;
  assign rdata = rdata_reg;
  assign busy  = (state_reg != IDLE);

endmodule
